// File: rtl/outbuf_drain.sv
// outbuf_drain: byte FIFO between the CPU bus and the output peripheral.
// The CPU writes 1-4 bytes per word access. The block drains one byte per
// clock as single-lane writes to OUT_BASE.
// Optional build macro: OUTBUF_PAUSE_EN adds a CTRL[1] pause flag that
// holds off draining.
//
// state | meaning
// IDLE  | no byte on the output bus this cycle
// SEND  | a popped byte is being written to the peripheral this cycle
module outbuf_drain #(
   parameter int          DEPTH    = 16,
   parameter logic [31:0] OUT_BASE = 32'h00034560
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwe,
   output logic [31:0] drdata,
   output logic [31:0] out_daddr,
   output logic [31:0] out_dwdata,
   output logic [3:0]  out_dwe
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [LW-1:0] level_q, level_d, room;
   logic          ovf_q, ovf_d;
   logic          pause_q;
   logic [31:0]   sent_q;
   logic [3:0]    out_dwe_q, out_dwe_d;
   logic [7:0]    out_byte_q, out_byte_d;

   logic [1:0]    sel;
   logic          wr_data, wr_ctrl, accept, pop;
   logic [2:0]    n;
   logic [1:0]    off [4];
   logic [7:0]    bypass_byte, pop_byte;
   logic          unused_addr;

   assign sel         = daddr[3:2];
   assign unused_addr = ^{daddr[31:4], daddr[1:0]};
   assign wr_data     = (sel == 2'd0) && (dwe != 4'b0000);
   assign wr_ctrl     = (sel == 2'd2) && (dwe != 4'b0000);
   assign n           = {2'b0, dwe[0]} + {2'b0, dwe[1]} + {2'b0, dwe[2]} + {2'b0, dwe[3]};
   assign room        = LW'(DEPTH) - level_q;
   // Room is judged on the start-of-cycle level; a same-cycle pop never helps.
   assign accept      = wr_data && (LW'(n) <= room);

   // Slot offset of each enabled lane, packing lanes in order 0..3.
   always_comb begin
      off[0] = 2'd0;
      off[1] = {1'b0, dwe[0]};
      off[2] = {1'b0, dwe[0]} + {1'b0, dwe[1]};
      off[3] = {1'b0, dwe[0]} + {1'b0, dwe[1]} + {1'b0, dwe[2]};
   end

   // First enabled lane, used when the FIFO is empty so a fresh byte leaves next cycle.
   always_comb begin
      bypass_byte = 8'h00;
      if (dwe[3]) bypass_byte = dwdata[31:24];
      if (dwe[2]) bypass_byte = dwdata[23:16];
      if (dwe[1]) bypass_byte = dwdata[15:8];
      if (dwe[0]) bypass_byte = dwdata[7:0];
   end

   // Pop whenever a byte is available, either buffered or arriving this cycle.
   assign pop      = ((level_q != '0) || accept) && !pause_q;
   assign pop_byte = (level_q != '0) ? mem_q[rptr_q] : bypass_byte;

   // Storage write: every accepted lane lands in the array, including a bypassed byte.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (accept && dwe[k]) mem_q[wptr_q + AW'(off[k])] <= dwdata[8*k +: 8];
      end
   end

   // Pointer, level and overflow next-state.
   always_comb begin
      wptr_d  = wptr_q + (accept ? AW'(n) : '0);
      rptr_d  = rptr_q + AW'(pop);
      level_d = level_q + (accept ? LW'(n) : '0) - LW'(pop);
      ovf_d   = ovf_q;
      if (wr_data && !accept) ovf_d = 1'b1;
      if (wr_ctrl && dwdata[0]) ovf_d = 1'b0;
   end

   // Drain FSM next state and registered output values.
   always_comb begin
      state_d    = IDLE;
      out_dwe_d  = 4'b0000;
      out_byte_d = 8'h00;
      if (pop) begin
         state_d    = SEND;
         out_dwe_d  = 4'b0001;
         out_byte_d = pop_byte;
      end
   end

   // State, FIFO control and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wptr_q     <= '0;
         rptr_q     <= '0;
         level_q    <= '0;
         ovf_q      <= 1'b0;
         sent_q     <= 32'd0;
         out_dwe_q  <= 4'b0000;
         out_byte_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         level_q    <= level_d;
         ovf_q      <= ovf_d;
         out_dwe_q  <= out_dwe_d;
         out_byte_q <= out_byte_d;
         if (out_dwe_q != 4'b0000) sent_q <= sent_q + 32'd1;
      end
   end

`ifdef OUTBUF_PAUSE_EN
   // Pause flag, rewritten from dwdata[1] on every CTRL write.
   always_ff @(posedge clk) begin
      if (reset)        pause_q <= 1'b0;
      else if (wr_ctrl) pause_q <= dwdata[1];
   end
`else
   assign pause_q = 1'b0;
`endif

   assign out_daddr  = OUT_BASE;
   assign out_dwe    = out_dwe_q;
   assign out_dwdata = (state_q == SEND) ? {24'h0, out_byte_q} : 32'h0;

   // CPU read mux.
   always_comb begin
      drdata = 32'h0;
      case (sel)
         2'd1: begin
            drdata[8:0] = 9'(level_q);
            drdata[16]  = (level_q == '0);
            drdata[17]  = (level_q == LW'(DEPTH));
            drdata[18]  = ovf_q;
            drdata[19]  = pause_q;
         end
         2'd2:    drdata[1] = pause_q;
         2'd3:    drdata = sent_q;
         default: drdata = 32'h0;
      endcase
   end

endmodule
